// File: rtl/mem_copy_engine.sv
// mem_copy_engine: owns the single-port data memory while Busy and either copies a block
// (one read cycle + one write cycle per byte) or fills a region (one write cycle per byte).
module mem_copy_engine #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         FillEn,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A:0]   Len,
    input  logic [W-1:0] FillValue,
    input  logic [W-1:0] MemDataIn,
    output logic [A-1:0] MemAddress,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataOut,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FIN
    } state_e;

    state_e         state_q, state_d;
    logic           fill_q, fill_d;
    logic [A-1:0]   src_q, src_d;
    logic [A-1:0]   dst_q, dst_d;
    logic [A:0]     len_q, len_d;
    logic [W-1:0]   fv_q, fv_d;
    logic [A:0]     idx_q, idx_d;
    logic [A-1:0]   addr_q, addr_d;
    logic           we_q, we_d;
    // The write-data register doubles as the hold register for the byte read in READ.
    logic [W-1:0]   wdata_q, wdata_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fv_d    = fv_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    fill_d = FillEn;
                    src_d  = SrcAddr;
                    dst_d  = DstAddr;
                    len_d  = Len;
                    fv_d   = FillValue;
                    idx_d  = '0;
                    if (Len == '0) begin
                        state_d = S_FIN;
                    end else if (FillEn) begin
                        state_d = S_WRITE;
                        addr_d  = DstAddr;
                        we_d    = 1'b1;
                        wdata_d = FillValue;
                    end else begin
                        state_d = S_READ;
                        addr_d  = SrcAddr;
                    end
                end
            end

            S_READ: begin
                state_d = S_WRITE;
                addr_d  = dst_q + idx_q[A-1:0];
                we_d    = 1'b1;
                wdata_d = MemDataIn;
            end

            S_WRITE: begin
                idx_d = idx_q + 1'b1;
                // Index and length compare at A+1 bits so Len = 2**A covers the whole memory.
                if (idx_d == len_q) begin
                    state_d = S_FIN;
                end else if (fill_q) begin
                    addr_d  = dst_q + idx_d[A-1:0];
                    we_d    = 1'b1;
                    wdata_d = fv_q;
                end else begin
                    state_d = S_READ;
                    addr_d  = src_q + idx_d[A-1:0];
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            fill_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fv_q    <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fv_q    <= fv_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign MemAddress = addr_q;
    assign MemWriteEn = we_q;
    assign MemDataOut = wdata_q;
    assign Busy       = (state_q == S_READ) || (state_q == S_WRITE);
    assign Done       = (state_q == S_FIN);

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-initiator block that drives the single-port data memory's address/write/data port to copy a block of bytes from a source region to a destination region, or to fill a region with a constant. It sits between the controller and the data memory and owns the memory port while Busy is high. The memory read is combinational and the write is sequential, so each copied byte takes one read cycle and one write cycle; each filled byte takes one write cycle.

## Interface
- W, 8, data width (bits per memory word)
- A, 8, address width (memory depth 2**A)

- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  launch request, sampled only in IDLE
- FillEn  in  1  1 = fill mode, 0 = copy mode; latched at Start
- SrcAddr  in  A  first source address; latched at Start; ignored in fill mode
- DstAddr  in  A  first destination address; latched at Start
- Len  in  A+1  byte count, 0..2**A; latched at Start
- FillValue  in  W  fill constant; latched at Start
- MemDataIn  in  W  read data from memory (combinational with MemAddress)
- MemAddress  out  A  memory address
- MemWriteEn  out  1  memory write enable
- MemDataOut  out  W  memory write data
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WRITE, FIN.
- IDLE: Busy=0, MemWriteEn=0. On Start=1: latch FillEn, SrcAddr, DstAddr, Len, FillValue; clear byte index i.
  - Len=0 -> FIN; FillEn=1 -> WRITE; else -> READ.
- READ (copy only): MemAddress=src+i; at clock edge capture MemDataIn into hold register; -> WRITE.
- WRITE: MemAddress=dst+i, MemWriteEn=1, MemDataOut=hold (copy) or latched FillValue (fill). At edge i increments.
  - If i+1 == Len -> FIN; else -> READ (copy) or WRITE (fill).
- FIN: Done=1, Busy=0, MemWriteEn=0; -> IDLE next cycle.
- Busy=1 in READ and WRITE only.
- Address arithmetic is modulo 2**A: src+i and dst+i wrap from 2**A-1 to 0. i and Len compare at A+1 bits, so Len=2**A transfers the full memory.
- Copy order is strictly ascending from index 0. Overlapping regions with dst>src propagate already-written data; no overlap detection is performed.
- Start while not in IDLE is ignored; input changes after Start have no effect on the transfer in progress.
- In IDLE and FIN, MemAddress and MemDataOut hold their last values; only MemWriteEn matters to the memory.

## Timing
- Reset (Reset=0, asynchronous): state IDLE, MemAddress=0, MemWriteEn=0, MemDataOut=0, Busy=0, Done=0, i=0, hold=0. MemWriteEn falls immediately, so no write occurs on a clock edge that arrives while Reset is low. Bytes already written stay in memory; the transfer is not resumed.
- Start sampled at edge k:
  - Copy of N>0 bytes: READ/WRITE alternate in cycles k+1..k+2N, with the byte-j write in cycle k+2j+2. Done is high in cycle k+2N+1.
  - Fill of N>0 bytes: writes in cycles k+1..k+N. Done is high in cycle k+N+1.
  - Len=0: Done is high in cycle k+1, with no memory write.
- Earliest next accepted Start is at the edge ending the FIN cycle plus one, i.e. the first IDLE cycle.
- MemAddress, MemWriteEn and MemDataOut are registered outputs, with no combinational path from inputs.

## Test plan
- Copy: memory preloaded Core[i]=i; Start, SrcAddr=0x10, DstAddr=0x80, Len=4, FillEn=0 -> Core[0x80..0x83]=0x10..0x13, exactly 4 write cycles, Done at k+9, Busy high for 8 cycles.
- Fill: DstAddr=0x20, Len=3, FillValue=0xA5, FillEn=1 -> Core[0x20..0x22]=0xA5, Core[0x23] unchanged, Done at k+4.
- Wrap and zero length: SrcAddr=0xFE, DstAddr=0x40, Len=4 on identity memory -> Core[0x40..0x43]=FE,FF,00,01. Len=0 -> Done at k+1, no MemWriteEn.
- Full length: fill with Len=256, FillValue=0x3C -> all 256 locations are 0x3C, 256 writes, Done at k+257.
- Start while Busy: a second Start with different operands during a copy -> ignored, and only the first transfer's writes appear.
- Reset mid-operation: assert Reset low during the WRITE of byte 2 of a Len=6 copy -> MemWriteEn=0 and Busy=0 immediately, bytes 0-1 written, bytes 2-5 untouched. After release the engine is in IDLE and a new Start works normally.
